// File: rtl/intbus_hub.sv
// ---------------------------------------------------------------------------
// intbus_hub
//
// Connects one internal-bus master (fed by the AXI3 bridge) to N_BUSES slave
// windows. The hub also owns a small header:
//   BASEADDR+0 : ID     {HUB_ID[15:0], N_BUSES[15:0]}, read-only
//   BASEADDR+1 : STATUS {16'b0, err_cnt[15:0]}, any write clears it
// Slave i occupies BASEADDR+HUBSIZE+i*WIN_SIZE .. +WIN_SIZE-1. Every other
// address is unmapped. All slave strobes are registered. At most one read
// is in flight at a time.
//
// Compile-time option:
//   INTBUS_HUB_TIMEOUT_EN - when defined, a slave read that gets no
//   s_rvalid within TIMEOUT cycles completes with ERR_DATA and m_err.
//   When undefined, WAIT_RD is left only on s_rvalid of the selected slave
//   or on rst, and TIMEOUT is ignored.
//
// Ports:
//   clk       in   clock, everything on the rising edge
//   rst       in   synchronous active-high reset
//   m_addr    in   master word address
//   m_wr      in   master write strobe (1-cycle pulse)
//   m_rd      in   master read strobe (1-cycle pulse)
//   m_wdata   in   master write data
//   m_rdata   out  read data, valid with m_rvalid
//   m_rvalid  out  read response pulse
//   m_err     out  error pulse (with m_rvalid, or alone for a dropped strobe)
//   m_busy    out  a read is outstanding; strobes are refused
//   s_addr    out  window-local word offset, shared by all slaves
//   s_wdata   out  shared write data
//   s_wr      out  one-hot slave write strobes
//   s_rd      out  one-hot slave read strobes
//   s_rdata   in   slave read data, slave i at [i*DATA_W +: DATA_W]
//   s_rvalid  in   slave read-valid pulses
// ---------------------------------------------------------------------------
module intbus_hub #(
  parameter int                BASEADDR = 0,
  parameter int                N_BUSES  = 2,
  parameter int                ADDR_W   = 30,
  parameter int                DATA_W   = 32,
  parameter int                HUBSIZE  = 2,
  parameter int                WIN_SIZE = 16,
  parameter int                TIMEOUT  = 255,
  parameter logic [15:0]       HUB_ID   = 16'h1,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_W-1:0]           m_addr,
  input  logic                        m_wr,
  input  logic                        m_rd,
  input  logic [DATA_W-1:0]           m_wdata,
  output logic [DATA_W-1:0]           m_rdata,
  output logic                        m_rvalid,
  output logic                        m_err,
  output logic                        m_busy,
  output logic [$clog2(WIN_SIZE)-1:0] s_addr,
  output logic [DATA_W-1:0]           s_wdata,
  output logic [N_BUSES-1:0]          s_wr,
  output logic [N_BUSES-1:0]          s_rd,
  input  logic [N_BUSES*DATA_W-1:0]   s_rdata,
  input  logic [N_BUSES-1:0]          s_rvalid
);

  localparam int LOC_W = $clog2(WIN_SIZE);
  localparam int SEL_W = (N_BUSES > 1) ? $clog2(N_BUSES) : 1;

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASEADDR);
  localparam logic [ADDR_W-1:0] HUB_A  = ADDR_W'(HUBSIZE);
  localparam logic [ADDR_W-1:0] SPAN_A = ADDR_W'(N_BUSES * WIN_SIZE);
  localparam logic [31:0]       ID_WORD = {HUB_ID, 16'(N_BUSES)};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_RD,
    ST_RESP
  } state_t;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t             r_state;
  logic [SEL_W-1:0]   r_sel;       // slave owning the outstanding read
  logic               r_local;     // outstanding read is answered by the hub
  logic               r_lerr;      // hub-answered read is an unmapped access
  logic [DATA_W-1:0]  r_rdata;
  logic               r_rvalid;
  logic               r_err;
  logic [15:0]        r_err_cnt;
  logic [N_BUSES-1:0] r_s_wr;
  logic [N_BUSES-1:0] r_s_rd;
  logic [LOC_W-1:0]   r_s_addr;
  logic [DATA_W-1:0]  r_s_wdata;

  // -------------------------------------------------------------------------
  // Next-state / combinational signals
  // -------------------------------------------------------------------------
  state_t             w_state_next;
  logic [SEL_W-1:0]   w_sel_next;
  logic               w_local_next;
  logic               w_lerr_next;
  logic [DATA_W-1:0]  w_rdata_next;
  logic               w_rvalid_next;
  logic               w_err_next;
  logic [15:0]        w_err_cnt_next;
  logic [N_BUSES-1:0] w_s_wr_next;
  logic [N_BUSES-1:0] w_s_rd_next;
  logic [LOC_W-1:0]   w_s_addr_next;
  logic [DATA_W-1:0]  w_s_wdata_next;

  logic               w_stat_clr;
  logic               w_ev_wr;     // rejected write (unmapped or while busy)
  logic               w_ev_rd;     // rejected read strobe
  logic               w_ev_resp;   // read completing with an error
  logic [1:0]         w_ev_cnt;
  logic [15:0]        w_cnt_base;
  logic [16:0]        w_cnt_sum;

  // -------------------------------------------------------------------------
  // Address decode. Offsets are taken relative to BASEADDR; addresses below
  // BASEADDR are excluded explicitly since the subtraction would wrap.
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0]  w_off;
  logic [ADDR_W-1:0]  w_win_off;
  logic               w_above_base;
  logic               w_is_id;
  logic               w_is_stat;
  logic               w_hit_win;
  logic [SEL_W-1:0]   w_sel;
  logic [LOC_W-1:0]   w_loc;
  logic [N_BUSES-1:0] w_sel_oh;

  assign w_off        = m_addr - BASE_A;
  assign w_win_off    = w_off - HUB_A;
  assign w_above_base = (m_addr >= BASE_A);
  assign w_is_id      = w_above_base && (w_off == ADDR_W'(0));
  assign w_is_stat    = w_above_base && (w_off == ADDR_W'(1));
  assign w_hit_win    = w_above_base && (w_off >= HUB_A) && (w_win_off < SPAN_A);
  assign w_sel        = w_win_off[LOC_W +: SEL_W];
  assign w_loc        = w_win_off[LOC_W-1:0];

  // One-hot select and per-slave read-data unpacking
  logic [DATA_W-1:0] w_s_rdata_arr [N_BUSES];

  generate
    for (genvar gi = 0; gi < N_BUSES; gi++) begin : g_slave
      assign w_sel_oh[gi]      = (w_sel == SEL_W'(gi));
      assign w_s_rdata_arr[gi] = s_rdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

`ifdef INTBUS_HUB_TIMEOUT_EN
  localparam logic [15:0] TMO_A = 16'(TIMEOUT);
  logic [15:0] r_tmo;
  logic [15:0] w_tmo_next;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^(16'(TIMEOUT));
`endif

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_sel_next     = r_sel;
    w_local_next   = r_local;
    w_lerr_next    = r_lerr;
    w_rdata_next   = r_rdata;
    w_rvalid_next  = 1'b0;
    w_s_wr_next    = '0;
    w_s_rd_next    = '0;
    w_s_addr_next  = r_s_addr;
    w_s_wdata_next = r_s_wdata;
    w_stat_clr     = 1'b0;
    w_ev_wr        = 1'b0;
    w_ev_rd        = 1'b0;
    w_ev_resp      = 1'b0;
`ifdef INTBUS_HUB_TIMEOUT_EN
    w_tmo_next     = r_tmo;
`endif

    case (r_state)
      ST_IDLE: begin
`ifdef INTBUS_HUB_TIMEOUT_EN
        w_tmo_next = '0;
`endif
        if (m_wr) begin
          if (w_hit_win) begin
            w_s_wr_next    = w_sel_oh;
            w_s_addr_next  = w_loc;
            w_s_wdata_next = m_wdata;
          end else if (w_is_stat) begin
            w_stat_clr = 1'b1;
          end else if (!w_is_id) begin
            // ID word is read-only: writes to it are silently ignored
            w_ev_wr = 1'b1;
          end
        end

        if (m_rd) begin
          if (m_wr) begin
            // Simultaneous strobes: the write wins, the read is rejected
            w_ev_rd = 1'b1;
          end else begin
            w_state_next = ST_WAIT_RD;
            if (w_hit_win) begin
              w_sel_next    = w_sel;
              w_s_rd_next   = w_sel_oh;
              w_s_addr_next = w_loc;
              w_local_next  = 1'b0;
              w_lerr_next   = 1'b0;
            end else begin
              // Hub-answered reads pass through WAIT_RD for one cycle so
              // they share the minimum two-cycle latency of slave reads.
              w_local_next = 1'b1;
              w_lerr_next  = !(w_is_id || w_is_stat);
              if (w_is_id)
                w_rdata_next = DATA_W'(ID_WORD);
              else if (w_is_stat)
                w_rdata_next = DATA_W'({16'h0000, r_err_cnt});
              else
                w_rdata_next = ERR_DATA;
            end
          end
        end
      end

      ST_WAIT_RD: begin
        w_ev_wr = m_wr;
        w_ev_rd = m_rd;
        if (r_local) begin
          w_state_next  = ST_RESP;
          w_rvalid_next = 1'b1;
          w_ev_resp     = r_lerr;
        end else if (s_rvalid[r_sel]) begin
          w_state_next  = ST_RESP;
          w_rvalid_next = 1'b1;
          w_rdata_next  = w_s_rdata_arr[r_sel];
        end
`ifdef INTBUS_HUB_TIMEOUT_EN
        // Counter reads c-1 in the c-th WAIT_RD cycle, so the timeout fires
        // after TIMEOUT full cycles of silence.
        else if (r_tmo == TMO_A) begin
          w_state_next  = ST_RESP;
          w_rvalid_next = 1'b1;
          w_rdata_next  = ERR_DATA;
          w_ev_resp     = 1'b1;
        end else begin
          w_tmo_next = r_tmo + 16'd1;
        end
`endif
      end

      ST_RESP: begin
        w_ev_wr      = m_wr;
        w_ev_rd      = m_rd;
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Several error events can merge into one m_err pulse; the counter
    // still accounts for each of them.
    w_err_next = w_ev_wr | w_ev_rd | w_ev_resp;
    w_ev_cnt   = 2'(w_ev_wr) + 2'(w_ev_rd) + 2'(w_ev_resp);

    // A status clear in the same cycle as new errors keeps the new errors.
    w_cnt_base     = w_stat_clr ? 16'h0000 : r_err_cnt;
    w_cnt_sum      = {1'b0, w_cnt_base} + 17'(w_ev_cnt);
    w_err_cnt_next = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_sel     <= '0;
      r_local   <= 1'b0;
      r_lerr    <= 1'b0;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_s_wr    <= '0;
      r_s_rd    <= '0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
`ifdef INTBUS_HUB_TIMEOUT_EN
      r_tmo     <= '0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_sel     <= w_sel_next;
      r_local   <= w_local_next;
      r_lerr    <= w_lerr_next;
      r_rdata   <= w_rdata_next;
      r_rvalid  <= w_rvalid_next;
      r_err     <= w_err_next;
      r_err_cnt <= w_err_cnt_next;
      r_s_wr    <= w_s_wr_next;
      r_s_rd    <= w_s_rd_next;
      r_s_addr  <= w_s_addr_next;
      r_s_wdata <= w_s_wdata_next;
`ifdef INTBUS_HUB_TIMEOUT_EN
      r_tmo     <= w_tmo_next;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign m_rdata  = r_rdata;
  assign m_rvalid = r_rvalid;
  assign m_err    = r_err;
  assign m_busy   = (r_state != ST_IDLE);
  assign s_addr   = r_s_addr;
  assign s_wdata  = r_s_wdata;
  assign s_wr     = r_s_wr;
  assign s_rd     = r_s_rd;

endmodule

// File: tb/tb_intbus_hub.sv
`timescale 1ns/1ps
module tb_intbus_hub;

  localparam int NB = 2;
  localparam int DW = 32;
  localparam int AW = 30;
  localparam int LW = 4;

`ifdef INTBUS_HUB_TIMEOUT_EN
  localparam logic [31:0] CNT_AFTER_SILENT = 32'd1;
`else
  localparam logic [31:0] CNT_AFTER_SILENT = 32'd0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    m_addr;
  logic             m_wr;
  logic             m_rd;
  logic [DW-1:0]    m_wdata;
  logic [DW-1:0]    m_rdata;
  logic             m_rvalid;
  logic             m_err;
  logic             m_busy;
  logic [LW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic [NB-1:0]    s_wr;
  logic [NB-1:0]    s_rd;
  logic [NB*DW-1:0] s_rdata;
  logic [NB-1:0]    s_rvalid;

  always #5 clk = ~clk;

  intbus_hub #(
    .BASEADDR (32'h100),
    .N_BUSES  (NB),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .HUBSIZE  (2),
    .WIN_SIZE (16),
    .TIMEOUT  (100),
    .HUB_ID   (16'h1),
    .ERR_DATA (32'hDEADBEEF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m_addr   (m_addr),
    .m_wr     (m_wr),
    .m_rd     (m_rd),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .m_rvalid (m_rvalid),
    .m_err    (m_err),
    .m_busy   (m_busy),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wr     (s_wr),
    .s_rd     (s_rd),
    .s_rdata  (s_rdata),
    .s_rvalid (s_rvalid)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } resp_t;

  resp_t sb[$];
  resp_t mon_e;
  int    c0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive point: 1 ns after the rising edge, strobes default low.
  task automatic step();
    @(posedge clk);
    #1;
    m_wr     = 1'b0;
    m_rd     = 1'b0;
    s_rvalid = '0;
  endtask

  // Sample point: falling edge of the current cycle.
  task automatic samp();
    @(negedge clk);
  endtask

  task automatic issue_rd(input logic [AW-1:0] a);
    step();
    m_addr = a;
    m_rd   = 1'b1;
    c0     = cyc;
  endtask

  task automatic issue_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step();
    m_addr  = a;
    m_wdata = d;
    m_wr    = 1'b1;
  endtask

  // Response monitor: every m_rvalid must match the head of the scoreboard.
  always @(negedge clk) begin
    if (m_rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", 64'(m_rvalid), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("resp_data", 64'(m_rdata), 64'(mon_e.data));
        chk("resp_err", 64'(m_err), 64'(mon_e.err));
        chk("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  initial begin
    rst      = 1'b1;
    m_addr   = '0;
    m_wr     = 1'b0;
    m_rd     = 1'b0;
    m_wdata  = '0;
    s_rdata  = '0;
    s_rvalid = '0;

    // ---------------- reset state ----------------
    repeat (3) step();
    samp();
    chk("rst_rvalid", 64'(m_rvalid), 64'(0));
    chk("rst_err",    64'(m_err),    64'(0));
    chk("rst_busy",   64'(m_busy),   64'(0));
    chk("rst_rdata",  64'(m_rdata),  64'(0));
    chk("rst_s_wr",   64'(s_wr),     64'(0));
    chk("rst_s_rd",   64'(s_rd),     64'(0));
    chk("rst_s_addr", 64'(s_addr),   64'(0));
    chk("rst_s_wdata",64'(s_wdata),  64'(0));
    step();
    rst = 1'b0;
    step();

    // ---------------- ID read ----------------
    issue_rd(30'h100);
    sb.push_back('{32'h00010002, 1'b0, c0 + 2});
    step(); samp();
    chk("id_busy_c1", 64'(m_busy), 64'(1));
    chk("id_srd_c1",  64'(s_rd),   64'(0));
    step(); samp();
    chk("id_busy_c2", 64'(m_busy), 64'(1));
    step(); samp();
    chk("id_busy_c3", 64'(m_busy), 64'(0));

    // ---------------- slave 1 write ----------------
    issue_wr(30'h112, 32'h0B0BADED);
    step(); samp();
    chk("wr_s_wr_c1",    64'(s_wr),    64'(2'b10));
    chk("wr_s_addr_c1",  64'(s_addr),  64'(0));
    chk("wr_s_wdata_c1", 64'(s_wdata), 64'(32'h0B0BADED));
    chk("wr_err_c1",     64'(m_err),   64'(0));
    step(); samp();
    chk("wr_s_wr_c2",    64'(s_wr),    64'(0));

    // ---------------- slave 0 read, answer in cycle 4 ----------------
    issue_rd(30'h105);
    sb.push_back('{32'h12345678, 1'b0, c0 + 5});
    step(); samp();
    chk("srd_s_rd_c1",   64'(s_rd),   64'(2'b01));
    chk("srd_s_addr_c1", 64'(s_addr), 64'(3));
    chk("srd_busy_c1",   64'(m_busy), 64'(1));
    step(); samp();
    chk("srd_s_rd_c2",   64'(s_rd),   64'(0));
    chk("srd_busy_c2",   64'(m_busy), 64'(1));
    step();
    s_rvalid = 2'b10;                 // unselected slave must be ignored
    s_rdata[63:32] = 32'hBAD0BAD0;
    samp();
    chk("srd_busy_c3",   64'(m_busy), 64'(1));
    step();
    s_rvalid = 2'b01;
    s_rdata[31:0] = 32'h12345678;
    samp();
    chk("srd_busy_c4",   64'(m_busy), 64'(1));
    step(); samp();
    chk("srd_busy_c5",   64'(m_busy), 64'(1));
    step(); samp();
    chk("srd_busy_c6",   64'(m_busy), 64'(0));

    // ---------------- silent slave ----------------
    issue_rd(30'h107);
`ifdef INTBUS_HUB_TIMEOUT_EN
    sb.push_back('{32'hDEADBEEF, 1'b1, c0 + 102});
    repeat (101) step();
    samp();
    chk("tmo_busy_c101",   64'(m_busy),   64'(1));
    chk("tmo_rvalid_c101", 64'(m_rvalid), 64'(0));
    step(); step(); samp();
    chk("tmo_busy_c103",   64'(m_busy),   64'(0));
`else
    repeat (110) step();
    samp();
    chk("notmo_busy", 64'(m_busy), 64'(1));
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    samp();
    chk("notmo_busy_after_rst", 64'(m_busy), 64'(0));
`endif
    issue_rd(30'h101);
    sb.push_back('{CNT_AFTER_SILENT, 1'b0, c0 + 2});
    repeat (3) step();
    issue_wr(30'h101, 32'hFFFFFFFF);
    step(); samp();
    chk("clr_err_c1", 64'(m_err), 64'(0));
    issue_rd(30'h101);
    sb.push_back('{32'h0, 1'b0, c0 + 2});
    repeat (3) step();

    // ---------------- unmapped read + strobe while busy ----------------
    issue_rd(30'h200);
    sb.push_back('{32'hDEADBEEF, 1'b1, c0 + 2});
    step();
    m_addr = 30'h100;
    m_rd   = 1'b1;
    samp();
    chk("unm_err_c1",  64'(m_err),  64'(0));
    step(); samp();
    chk("unm_err_c2",  64'(m_err),  64'(1));
    step(); samp();
    chk("unm_err_c3",  64'(m_err),  64'(0));
    chk("unm_busy_c3", 64'(m_busy), 64'(0));
    issue_rd(30'h101);
    sb.push_back('{32'd2, 1'b0, c0 + 2});
    repeat (3) step();

    // ---------------- simultaneous write+read, unmapped write ----------------
    step();
    m_addr  = 30'h113;
    m_wdata = 32'hCAFE0001;
    m_wr    = 1'b1;
    m_rd    = 1'b1;
    step(); samp();
    chk("wrrd_s_wr_c1",   64'(s_wr),   64'(2'b10));
    chk("wrrd_s_addr_c1", 64'(s_addr), 64'(1));
    chk("wrrd_s_rd_c1",   64'(s_rd),   64'(0));
    chk("wrrd_err_c1",    64'(m_err),  64'(1));
    chk("wrrd_busy_c1",   64'(m_busy), 64'(0));
    step(); samp();
    chk("wrrd_err_c2",    64'(m_err),  64'(0));
    issue_wr(30'h0FF, 32'h11111111);
    step(); samp();
    chk("unmwr_err_c1",   64'(m_err),  64'(1));
    chk("unmwr_s_wr_c1",  64'(s_wr),   64'(0));
    issue_rd(30'h101);
    sb.push_back('{32'd4, 1'b0, c0 + 2});
    repeat (3) step();
    issue_wr(30'h101, 32'h0);
    step();

    // ---------------- reset in the middle of a slave read ----------------
    issue_rd(30'h102);
    step();
    step();
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    samp();
    chk("abort_busy_c4", 64'(m_busy), 64'(0));
    step();
    s_rvalid = 2'b01;
    s_rdata[31:0] = 32'h55AA55AA;
    step(); samp();
    chk("abort_busy_c6", 64'(m_busy), 64'(0));
    step();
    issue_rd(30'h101);
    sb.push_back('{32'h0, 1'b0, c0 + 2});
    repeat (4) step();

    samp();
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
